// File: rtl/btn_gesture_decoder.sv
// Multi-channel push-button front end: each channel synchronises, debounces and
// classifies gestures into one-cycle short-click, double-click and long-press pulses.
module btn_gesture_decoder #(
  parameter int N_CH       = 4,
  parameter int DEB_CYC    = 250000,
  parameter int LONG_CYC   = 50000000,
  parameter int DCLICK_CYC = 15000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] short_p,
  output logic [N_CH-1:0] double_p,
  output logic [N_CH-1:0] long_p
);

  localparam int DC_W  = $clog2(DEB_CYC + 1);
  localparam int T_MAX = (LONG_CYC > DCLICK_CYC) ? LONG_CYC : DCLICK_CYC;
  localparam int T_W   = $clog2(T_MAX + 1);

  localparam logic [DC_W-1:0] DC_LAST     = DC_W'(DEB_CYC - 1);
  localparam logic [T_W-1:0]  LONG_LAST   = T_W'(LONG_CYC - 1);
  localparam logic [T_W-1:0]  DCLICK_LAST = T_W'(DCLICK_CYC - 1);
  localparam logic            RAW_IDLE    = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS1 = 2'd1,
    WAIT2  = 2'd2,
    HELD   = 2'd3
  } state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic            sync_p0;
    logic            sync_p1;
    logic            s_p1;
    logic [DC_W-1:0] dc_p2;
    logic            lvl_p2;
    logic            lvl_p3;
    logic            pe_p3;
    logic            re_p3;
    state_t          state_p4;
    logic [T_W-1:0]  t_p4;
    logic            short_p4;
    logic            double_p4;
    logic            long_p4;

    // Stage 0/1: two-flop synchroniser, reset to the released raw level
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_p0 <= RAW_IDLE;
        sync_p1 <= RAW_IDLE;
      end else begin
        sync_p0 <= btn_raw[i];
        sync_p1 <= sync_p0;
      end
    end

    assign s_p1 = sync_p1 ^ RAW_IDLE;

    // Stage 2: debouncer, any disagreement shorter than DEB_CYC restarts the count
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dc_p2  <= '0;
        lvl_p2 <= 1'b0;
      end else if (s_p1 != lvl_p2) begin
        if (dc_p2 == DC_LAST) begin
          lvl_p2 <= ~lvl_p2;
          dc_p2  <= '0;
        end else begin
          dc_p2 <= dc_p2 + 1'b1;
        end
      end else begin
        dc_p2 <= '0;
      end
    end

    // Stage 3: edge detect against a registered copy of the debounced level
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lvl_p3 <= 1'b0;
      end else begin
        lvl_p3 <= lvl_p2;
      end
    end

    assign pe_p3 = lvl_p2 & ~lvl_p3;
    assign re_p3 = ~lvl_p2 & lvl_p3;

    // Stage 4: gesture FSM; the edge cycle itself is t = 0, so the first state cycle holds t = 1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_p4  <= IDLE;
        t_p4      <= '0;
        short_p4  <= 1'b0;
        double_p4 <= 1'b0;
        long_p4   <= 1'b0;
      end else begin
        short_p4  <= 1'b0;
        double_p4 <= 1'b0;
        long_p4   <= 1'b0;
        case (state_p4)
          IDLE: begin
            t_p4 <= '0;
            if (pe_p3) begin
              state_p4 <= PRESS1;
              t_p4     <= T_W'(1);
            end
          end
          PRESS1: begin
            t_p4 <= t_p4 + 1'b1;
            if (lvl_p2 && (t_p4 == LONG_LAST)) begin
              long_p4  <= 1'b1;
              state_p4 <= HELD;
              t_p4     <= '0;
            end else if (re_p3) begin
              state_p4 <= WAIT2;
              t_p4     <= T_W'(1);
            end
          end
          WAIT2: begin
            t_p4 <= t_p4 + 1'b1;
            if (pe_p3) begin
              double_p4 <= 1'b1;
              state_p4  <= HELD;
              t_p4      <= '0;
            end else if (t_p4 == DCLICK_LAST) begin
              short_p4 <= 1'b1;
              state_p4 <= IDLE;
              t_p4     <= '0;
            end
          end
          HELD: begin
            t_p4 <= '0;
            if (re_p3) begin
              state_p4 <= IDLE;
            end
          end
          default: begin
            state_p4 <= IDLE;
            t_p4     <= '0;
          end
        endcase
      end
    end

    assign level[i]    = lvl_p2;
    assign short_p[i]  = short_p4;
    assign double_p[i] = double_p4;
    assign long_p[i]   = long_p4;
  end

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Directed bench for btn_gesture_decoder: two channels, short timing parameters,
// event counters per channel and hand-computed gesture latencies.
module tb_btn_gesture_decoder;

  localparam int N_CH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] short_p;
  logic [N_CH-1:0] double_p;
  logic [N_CH-1:0] long_p;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  int rise_cnt[N_CH];
  int fall_cnt[N_CH];
  int rise_cyc[N_CH];
  int fall_cyc[N_CH];
  int sp_cnt[N_CH];
  int dp_cnt[N_CH];
  int lp_cnt[N_CH];
  int sp_cyc[N_CH];
  int dp_cyc[N_CH];
  int lp_cyc[N_CH];
  bit [N_CH-1:0] lvl_prev;

  int b_rise[N_CH];
  int b_fall[N_CH];
  int b_sp[N_CH];
  int b_dp[N_CH];
  int b_lp[N_CH];

  btn_gesture_decoder #(
    .N_CH      (N_CH),
    .DEB_CYC   (4),
    .LONG_CYC  (40),
    .DCLICK_CYC(20),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .level   (level),
    .short_p (short_p),
    .double_p(double_p),
    .long_p  (long_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (level[c] && !lvl_prev[c]) begin
        rise_cnt[c]++;
        rise_cyc[c] = cyc;
      end
      if (!level[c] && lvl_prev[c]) begin
        fall_cnt[c]++;
        fall_cyc[c] = cyc;
      end
      if (short_p[c]) begin
        sp_cnt[c]++;
        sp_cyc[c] = cyc;
      end
      if (double_p[c]) begin
        dp_cnt[c]++;
        dp_cyc[c] = cyc;
      end
      if (long_p[c]) begin
        lp_cnt[c]++;
        lp_cyc[c] = cyc;
      end
    end
    lvl_prev = level;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    for (int c = 0; c < N_CH; c++) begin
      b_rise[c] = rise_cnt[c];
      b_fall[c] = fall_cnt[c];
      b_sp[c]   = sp_cnt[c];
      b_dp[c]   = dp_cnt[c];
      b_lp[c]   = lp_cnt[c];
    end
  endtask

  task automatic click(input int ch, input int hold);
    btn_raw[ch] = 1'b0;
    wait_cyc(hold);
    btn_raw[ch] = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_level"}, int'(level), 0);
    check_eq({tag, "_short"}, int'(short_p), 0);
    check_eq({tag, "_double"}, int'(double_p), 0);
    check_eq({tag, "_long"}, int'(long_p), 0);
  endtask

  initial begin
    int t_last;

    rst     = 1'b1;
    btn_raw = '1;
    wait_cyc(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    wait_cyc(8);
    check_eq("post_reset_level", int'(level), 0);
    check_eq("post_reset_edges", rise_cnt[0] + rise_cnt[1], 0);

    // Bounce: 2-cycle pulses never qualify; the final hold rises level 6 cycles later
    snap();
    t_last = cyc;
    for (int i = 0; i < 6; i++) begin
      btn_raw[0] = ~btn_raw[0];
      wait_cyc(2);
    end
    btn_raw[0] = 1'b0;
    t_last = cyc;
    wait_cyc(20);
    check_eq("bounce_rises", rise_cnt[0] - b_rise[0], 1);
    check_eq("bounce_falls", fall_cnt[0] - b_fall[0], 0);
    check_eq("bounce_latency", rise_cyc[0] - t_last, 6);
    check_eq("bounce_ch1_quiet",
             (rise_cnt[1] - b_rise[1]) + (sp_cnt[1] - b_sp[1]) +
             (dp_cnt[1] - b_dp[1]) + (lp_cnt[1] - b_lp[1]), 0);
    btn_raw[0] = 1'b1;
    wait_cyc(50);

    // Single click
    snap();
    click(0, 12);
    wait_cyc(40);
    check_eq("single_short_cnt", sp_cnt[0] - b_sp[0], 1);
    check_eq("single_short_lat", sp_cyc[0] - fall_cyc[0], 20);
    check_eq("single_double_cnt", dp_cnt[0] - b_dp[0], 0);
    check_eq("single_long_cnt", lp_cnt[0] - b_lp[0], 0);

    // Double click
    snap();
    click(0, 12);
    wait_cyc(10);
    click(0, 12);
    wait_cyc(40);
    check_eq("double_rises", rise_cnt[0] - b_rise[0], 2);
    check_eq("double_double_cnt", dp_cnt[0] - b_dp[0], 1);
    check_eq("double_double_lat", dp_cyc[0] - rise_cyc[0], 1);
    check_eq("double_short_cnt", sp_cnt[0] - b_sp[0], 0);
    check_eq("double_long_cnt", lp_cnt[0] - b_lp[0], 0);

    // Long press
    snap();
    click(0, 60);
    wait_cyc(40);
    check_eq("long_long_cnt", lp_cnt[0] - b_lp[0], 1);
    check_eq("long_long_lat", lp_cyc[0] - rise_cyc[0], 40);
    check_eq("long_short_cnt", sp_cnt[0] - b_sp[0], 0);
    check_eq("long_double_cnt", dp_cnt[0] - b_dp[0], 0);

    // Second press rising in the last cycle of the window still counts as double
    snap();
    click(0, 12);
    wait_cyc(19);
    click(0, 12);
    wait_cyc(40);
    check_eq("edge19_double_cnt", dp_cnt[0] - b_dp[0], 1);
    check_eq("edge19_short_cnt", sp_cnt[0] - b_sp[0], 0);

    // One cycle later the window has closed: two separate single clicks
    snap();
    click(0, 12);
    wait_cyc(20);
    click(0, 12);
    wait_cyc(40);
    check_eq("edge20_double_cnt", dp_cnt[0] - b_dp[0], 0);
    check_eq("edge20_short_cnt", sp_cnt[0] - b_sp[0], 2);

    // Parallel channels: ch0 short click, ch1 long press, pressed together
    snap();
    btn_raw = 2'b00;
    wait_cyc(12);
    btn_raw[0] = 1'b1;
    wait_cyc(48);
    btn_raw[1] = 1'b1;
    wait_cyc(40);
    check_eq("par_ch0_short_cnt", sp_cnt[0] - b_sp[0], 1);
    check_eq("par_ch0_short_lat", sp_cyc[0] - fall_cyc[0], 20);
    check_eq("par_ch1_long_cnt", lp_cnt[1] - b_lp[1], 1);
    check_eq("par_ch1_long_lat", lp_cyc[1] - rise_cyc[1], 40);
    check_eq("par_ch0_long_cnt", lp_cnt[0] - b_lp[0], 0);
    check_eq("par_ch1_short_cnt", sp_cnt[1] - b_sp[1], 0);
    check_eq("par_double_cnt", (dp_cnt[0] - b_dp[0]) + (dp_cnt[1] - b_dp[1]), 0);

    // Reset while channel 0 waits for a second press discards the click
    snap();
    click(0, 12);
    wait_cyc(8);
    rst = 1'b1;
    wait_cyc(2);
    check_outputs_zero("midrst");
    rst = 1'b0;
    wait_cyc(40);
    check_eq("midrst_short_cnt", sp_cnt[0] - b_sp[0], 0);
    check_eq("midrst_other_cnt", (dp_cnt[0] - b_dp[0]) + (lp_cnt[0] - b_lp[0]), 0);
    check_eq("midrst_level", int'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
